// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with valid/ready handshakes, operand
// muxing, hazard detection and a saturating bubble counter.
// Optional build macro ID_EX_FORWARDING_EN enables EX/MEM and MEM/WB operand
// forwarding. With forwarding, only load-use stalls. Without it, any
// in-flight writer of a used source register stalls.
module id_ex_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    // decode-side handshake and fields
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [4:0]      in_rd,
    input  logic            in_use_rs1,
    input  logic            in_use_rs2,
    input  logic [3:0]      in_alu_ctrl,
    input  logic [1:0]      in_src_a,
    input  logic            in_src_b,
    input  logic [7:0]      in_ctrl,
    input  logic            flush,
    // EX/MEM stage state
    input  logic            mem_valid,
    input  logic            mem_regwrite,
    input  logic            mem_is_load,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    // MEM/WB stage state
    input  logic            wb_valid,
    input  logic            wb_regwrite,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    // execute-side handshake and payload
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] out_store_data,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [7:0]      out_ctrl,
    output logic [31:0]     bubble_count
);

    localparam int unsigned RegW  = 5;
    localparam int unsigned AluW  = 4;
    localparam int unsigned CtrlW = 8;
    localparam int unsigned CntW  = 32;

    logic            valid_q,    valid_d;
    logic [XLEN-1:0] pc_q,       pc_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q,      imm_d;
    logic [RegW-1:0] rs1_q,      rs1_d;
    logic [RegW-1:0] rs2_q,      rs2_d;
    logic [RegW-1:0] rd_q,       rd_d;
    logic            use_rs1_q,  use_rs1_d;
    logic            use_rs2_q,  use_rs2_d;
    logic [AluW-1:0] alu_ctrl_q, alu_ctrl_d;
    logic [1:0]      src_a_q,    src_a_d;
    logic            src_b_q,    src_b_d;
    logic [CtrlW-1:0] ctrl_q,    ctrl_d;
    logic [CntW-1:0] bubble_q,   bubble_d;

    logic            hazard;
    logic            accept;
    logic            fire;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    // Register-address matches against later stages; x0 never matches
    logic rs1_nz, rs2_nz;
    logic rs1_mem_match, rs2_mem_match, rs1_wb_match, rs2_wb_match;

    assign rs1_nz        = (rs1_q != RegW'(0));
    assign rs2_nz        = (rs2_q != RegW'(0));
    assign rs1_mem_match = rs1_nz && (mem_rd == rs1_q);
    assign rs2_mem_match = rs2_nz && (mem_rd == rs2_q);
    assign rs1_wb_match  = rs1_nz && (wb_rd == rs1_q);
    assign rs2_wb_match  = rs2_nz && (wb_rd == rs2_q);

`ifdef ID_EX_FORWARDING_EN
    logic mem_fwd_ok, wb_fwd_ok;
    assign mem_fwd_ok = mem_valid && mem_regwrite && !mem_is_load;
    assign wb_fwd_ok  = wb_valid && wb_regwrite;

    // Load-use is the only stall; everything else is bypassed, EX/MEM first
    always_comb begin
        hazard  = mem_valid && mem_is_load &&
                  ((use_rs1_q && rs1_mem_match) || (use_rs2_q && rs2_mem_match));
        rs1_fwd = rs1_data_q;
        rs2_fwd = rs2_data_q;
        if (mem_fwd_ok && rs1_mem_match)     rs1_fwd = mem_data;
        else if (wb_fwd_ok && rs1_wb_match)  rs1_fwd = wb_data;
        if (mem_fwd_ok && rs2_mem_match)     rs2_fwd = mem_data;
        else if (wb_fwd_ok && rs2_wb_match)  rs2_fwd = wb_data;
    end
`else
    logic mem_wr, wb_wr;
    logic unused_no_fwd;
    assign mem_wr        = mem_valid && mem_regwrite;
    assign wb_wr         = wb_valid && wb_regwrite;
    assign unused_no_fwd = ^{mem_is_load, mem_data, wb_data};

    // No bypass: stall until no older in-flight instruction writes a used source
    always_comb begin
        hazard  = (use_rs1_q && ((mem_wr && rs1_mem_match) || (wb_wr && rs1_wb_match))) ||
                  (use_rs2_q && ((mem_wr && rs2_mem_match) || (wb_wr && rs2_wb_match)));
        rs1_fwd = rs1_data_q;
        rs2_fwd = rs2_data_q;
    end
`endif

    assign out_valid = valid_q && !hazard;
    assign fire      = out_valid && out_ready;
    assign in_ready  = !valid_q || fire;
    assign accept    = in_valid && in_ready;

    // Operand muxes on the held select fields
    always_comb begin
        alu_a = '0;
        case (src_a_q)
            2'b00:   alu_a = rs1_fwd;
            2'b01:   alu_a = pc_q;
            default: alu_a = '0;
        endcase
        alu_b = src_b_q ? imm_q : rs2_fwd;
    end

    assign out_store_data = rs2_fwd;
    assign out_pc         = pc_q;
    assign out_imm        = imm_q;
    assign out_rd         = rd_q;
    assign out_ctrl       = ctrl_q;
    assign alu_ctrl       = alu_ctrl_q;
    assign bubble_count   = bubble_q;

    // Next-state: slot occupancy, payload capture and bubble counting
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        use_rs1_d  = use_rs1_q;
        use_rs2_d  = use_rs2_q;
        alu_ctrl_d = alu_ctrl_q;
        src_a_d    = src_a_q;
        src_b_d    = src_b_q;
        ctrl_d     = ctrl_q;
        bubble_d   = bubble_q;

        if (flush)       valid_d = 1'b0;
        else if (accept) valid_d = 1'b1;
        else if (fire)   valid_d = 1'b0;

        if (accept) begin
            pc_d       = in_pc;
            rs1_data_d = in_rs1_data;
            rs2_data_d = in_rs2_data;
            imm_d      = in_imm;
            rs1_d      = in_rs1;
            rs2_d      = in_rs2;
            rd_d       = in_rd;
            use_rs1_d  = in_use_rs1;
            use_rs2_d  = in_use_rs2;
            alu_ctrl_d = in_alu_ctrl;
            src_a_d    = in_src_a;
            src_b_d    = in_src_b;
            ctrl_d     = in_ctrl;
        end

        if (valid_q && hazard && (bubble_q != {CntW{1'b1}}))
            bubble_d = bubble_q + CntW'(1);
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            use_rs1_q  <= 1'b0;
            use_rs2_q  <= 1'b0;
            alu_ctrl_q <= '0;
            src_a_q    <= '0;
            src_b_q    <= 1'b0;
            ctrl_q     <= '0;
            bubble_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            use_rs1_q  <= use_rs1_d;
            use_rs2_q  <= use_rs2_d;
            alu_ctrl_q <= alu_ctrl_d;
            src_a_q    <= src_a_d;
            src_b_q    <= src_b_d;
            ctrl_q     <= ctrl_d;
            bubble_q   <= bubble_d;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expectations follow the build's
// ID_EX_FORWARDING_EN setting.
module tb_id_ex_stage;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            reset_n;
    logic            in_valid, in_ready;
    logic [XLEN-1:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]      in_rs1, in_rs2, in_rd;
    logic            in_use_rs1, in_use_rs2;
    logic [3:0]      in_alu_ctrl;
    logic [1:0]      in_src_a;
    logic            in_src_b;
    logic [7:0]      in_ctrl;
    logic            flush;
    logic            mem_valid, mem_regwrite, mem_is_load;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            wb_valid, wb_regwrite;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] alu_a, alu_b, out_store_data, out_pc, out_imm;
    logic [3:0]      alu_ctrl;
    logic [4:0]      out_rd;
    logic [7:0]      out_ctrl;
    logic [31:0]     bubble_count;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_alu_ctrl(in_alu_ctrl), .in_src_a(in_src_a), .in_src_b(in_src_b), .in_ctrl(in_ctrl),
        .flush(flush),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_is_load(mem_is_load),
        .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .out_store_data(out_store_data), .out_pc(out_pc), .out_imm(out_imm),
        .out_rd(out_rd), .out_ctrl(out_ctrl), .bubble_count(bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] r1d, input logic [31:0] r2d,
                         input logic [31:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic [1:0] sa, input logic sb, input logic [3:0] alu,
                         input logic [7:0] ctrl);
        in_pc = pc; in_rs1_data = r1d; in_rs2_data = r2d; in_imm = imm;
        in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_use_rs1 = u1; in_use_rs2 = u2;
        in_src_a = sa; in_src_b = sb; in_alu_ctrl = alu; in_ctrl = ctrl;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1'b0, 4'h0, 8'h00);
        mem_valid = 0; mem_regwrite = 0; mem_is_load = 0; mem_rd = 0; mem_data = 0;
        wb_valid = 0; wb_regwrite = 0; wb_rd = 0; wb_data = 0;

        // reset state
        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_bubble", bubble_count, 0);
        chk("rst_out_pc", out_pc, 0);

        // back-to-back stream, first accept on first edge after reset release
        #5 reset_n = 1'b1;
        drive(32'h100, 32'h11, 32'h22, 32'h33, 1, 2, 3, 0, 0, 2'b00, 1'b0, 4'h3, 8'hA5);
        in_valid = 1'b1;
        #1 chk("a_in_ready", 32'(in_ready), 1);
        tick();
        chk("a_valid", 32'(out_valid), 1);
        chk("a_alu_a", alu_a, 32'h11);
        chk("a_alu_b", alu_b, 32'h22);
        chk("a_store", out_store_data, 32'h22);
        chk("a_pc", out_pc, 32'h100);
        chk("a_imm", out_imm, 32'h33);
        chk("a_rd", 32'(out_rd), 3);
        chk("a_ctrl", 32'(out_ctrl), 32'hA5);
        chk("a_alu_ctrl", 32'(alu_ctrl), 3);
        chk("a_in_ready_busy", 32'(in_ready), 1);
        drive(32'h200, 32'h1111, 32'h2222, 32'h44, 1, 2, 4, 0, 0, 2'b01, 1'b1, 4'h5, 8'h5A);
        tick();
        chk("b_valid", 32'(out_valid), 1);
        chk("b_alu_a_pc", alu_a, 32'h200);
        chk("b_alu_b_imm", alu_b, 32'h44);
        chk("b_store", out_store_data, 32'h2222);
        chk("b_in_ready", 32'(in_ready), 1);
        drive(32'h300, 32'h3333, 32'h6666, 32'h55, 1, 2, 5, 0, 0, 2'b10, 1'b0, 4'h6, 8'h11);
        tick();
        chk("c_valid", 32'(out_valid), 1);
        chk("c_alu_a_zero", alu_a, 0);
        chk("c_alu_b", alu_b, 32'h6666);
        drive(32'h400, 32'h4444, 32'h8888, 32'h77, 1, 2, 6, 0, 0, 2'b11, 1'b1, 4'h7, 8'h22);
        tick();
        chk("d_alu_a_rsvd", alu_a, 0);
        chk("d_alu_b", alu_b, 32'h77);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 0);
        chk("drain_in_ready", 32'(in_ready), 1);

        // back-pressure holds the slot, then flush empties it
        drive(32'h500, 32'hE1, 32'hE2, 32'h0, 1, 2, 7, 0, 0, 2'b00, 1'b0, 4'h1, 8'h33);
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        chk("e_valid", 32'(out_valid), 1);
        chk("e_in_ready", 32'(in_ready), 0);
        drive(32'h600, 32'hF1, 32'hF2, 32'h0, 1, 2, 8, 0, 0, 2'b00, 1'b0, 4'h2, 8'h44);
        tick();
        chk("stall1_in_ready", 32'(in_ready), 0);
        chk("stall1_alu_a", alu_a, 32'hE1);
        chk("stall1_pc", out_pc, 32'h500);
        tick();
        chk("stall2_alu_a", alu_a, 32'hE1);
        chk("stall2_valid", 32'(out_valid), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        out_ready = 1'b1; in_valid = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1 chk("flush_accept_valid", 32'(out_valid), 0);

        // rs1 matches both EX/MEM and MEM/WB writers
        mem_valid = 1; mem_regwrite = 1; mem_rd = 5; mem_data = 32'h10; mem_is_load = 0;
        wb_valid = 1; wb_regwrite = 1; wb_rd = 5; wb_data = 32'h20;
        drive(32'h700, 32'h55, 32'h66, 32'h0, 5, 6, 9, 1, 0, 2'b00, 1'b0, 4'h0, 8'h00);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
`ifdef ID_EX_FORWARDING_EN
        chk("fwd_valid", 32'(out_valid), 1);
        chk("fwd_mem_wins", alu_a, 32'h10);
        mem_valid = 0;
        #1 chk("fwd_wb", alu_a, 32'h20);
        wb_valid = 0;
        #1 chk("fwd_none", alu_a, 32'h55);
        tick();
        chk("fwd_drain", 32'(out_valid), 0);
        // load-use on rs2: one bubble, then the value comes from MEM/WB
        mem_valid = 1; mem_is_load = 1; mem_regwrite = 1; mem_rd = 7;
        drive(32'h800, 32'h70, 32'h77, 32'h0, 0, 7, 10, 0, 1, 2'b00, 1'b0, 4'h0, 8'h00);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        chk("lu_valid", 32'(out_valid), 0);
        chk("lu_bubble0", bubble_count, 0);
        tick();
        mem_valid = 0; mem_is_load = 0;
        wb_valid = 1; wb_regwrite = 1; wb_rd = 7; wb_data = 32'h99;
        #1;
        chk("lu_valid_after", 32'(out_valid), 1);
        chk("lu_bubble1", bubble_count, 1);
        chk("lu_alu_b", alu_b, 32'h99);
        chk("lu_store", out_store_data, 32'h99);
        tick();
        wb_valid = 0;
        chk("lu_drain", 32'(out_valid), 0);
`else
        chk("haz_valid", 32'(out_valid), 0);
        chk("haz_in_ready", 32'(in_ready), 0);
        chk("haz_bubble0", bubble_count, 0);
        chk("haz_alu_a", alu_a, 32'h55);
        tick();
        mem_valid = 0;
        #1;
        chk("haz_wb_valid", 32'(out_valid), 0);
        chk("haz_bubble1", bubble_count, 1);
        tick();
        wb_valid = 0;
        #1;
        chk("haz_clear_valid", 32'(out_valid), 1);
        chk("haz_clear_alu_a", alu_a, 32'h55);
        chk("haz_bubble2", bubble_count, 2);
        tick();
        chk("haz_drain", 32'(out_valid), 0);
`endif

        // x0 never matches a writer
        mem_valid = 1; mem_regwrite = 1; mem_rd = 0; mem_data = 32'hFF; mem_is_load = 0;
        wb_valid = 1; wb_regwrite = 1; wb_rd = 0; wb_data = 32'hEE;
        drive(32'h880, 32'hAB, 32'hCD, 32'h0, 0, 0, 11, 1, 1, 2'b00, 1'b0, 4'h0, 8'h00);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        chk("x0_valid", 32'(out_valid), 1);
        chk("x0_alu_a", alu_a, 32'hAB);
        chk("x0_alu_b", alu_b, 32'hCD);
        tick();
        mem_valid = 0; wb_valid = 0;

        // asynchronous reset while holding a valid instruction
        out_ready = 1'b0;
        drive(32'h900, 32'h91, 32'h92, 32'h0, 1, 2, 12, 0, 0, 2'b00, 1'b0, 4'h0, 8'h00);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        chk("pre_rst_valid", 32'(out_valid), 1);
`ifdef ID_EX_FORWARDING_EN
        chk("pre_rst_bubble", bubble_count, 1);
`else
        chk("pre_rst_bubble", bubble_count, 2);
`endif
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_bubble", bubble_count, 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        chk("mid_rst_pc", out_pc, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        #2 reset_n = 1'b1;
        drive(32'hA00, 32'hA1, 32'hA2, 32'h0, 1, 2, 13, 0, 0, 2'b00, 1'b0, 4'h0, 8'h00);
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        chk("post_rst_valid", 32'(out_valid), 1);
        chk("post_rst_pc", out_pc, 32'hA00);
        tick();
        chk("post_rst_drain", 32'(out_valid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
